// File: rtl/jump_target_unit.sv
// jump_target_unit
//   Resolves jump targets for four modes: PC-relative (00), register-indirect
//   JR (01), JALR with link (10) and JAL with link (11). The result goes
//   through one registered stage that supports stall and flush. The unit
//   flags signed overflow and misaligned targets. A circular return-address
//   stack (RAS) predicts return targets and reports mispredictions.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   valid_in          a jump is presented this cycle
//   mode[1:0]         jump mode (see above)
//   rs_is_link        Rs is the link register; JR/JALR is a return
//   pc, rs, imm_ext   PC, Rs value, sign-extended immediate
//   stall, flush      hold the stage / kill the stage contents
//   valid_out         stage holds a resolved jump
//   target, link      jump target, pc+PC_INC
//   link_we           jump writes the link register
//   err, misalign     signed overflow on the target add, target bit 0 set
//   ras_hit, ras_pred return popped a valid entry, popped entry
//   mispredict        ras_hit and ras_pred != target
//   ras_count         occupied RAS entries
module jump_target_unit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned PC_INC    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [1:0]                   mode,
    input  logic                         rs_is_link,
    input  logic [WIDTH-1:0]             pc,
    input  logic [WIDTH-1:0]             rs,
    input  logic [WIDTH-1:0]             imm_ext,
    input  logic                         stall,
    input  logic                         flush,
    output logic                         valid_out,
    output logic [WIDTH-1:0]             target,
    output logic [WIDTH-1:0]             link,
    output logic                         link_we,
    output logic                         err,
    output logic                         misalign,
    output logic                         ras_hit,
    output logic [WIDTH-1:0]             ras_pred,
    output logic                         mispredict,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        MODE_PC_REL = 2'b00,
        MODE_JR     = 2'b01,
        MODE_JALR   = 2'b10,
        MODE_JAL    = 2'b11
    } modeT;

    modeT             modeSel;
    logic             useRs;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] sum;
    logic             overflow;
    logic [WIDTH-1:0] linkAddr;
    logic             isReturn;
    logic             doPush;
    logic             popHit;
    logic             accept;
    logic [PTR_W-1:0] topMinus1;
    logic [WIDTH-1:0] predVal;

    logic [WIDTH-1:0] rasMem [RAS_DEPTH];
    logic [PTR_W-1:0] rasTop;
    logic [CNT_W-1:0] rasCount;

    assign modeSel = modeT'(mode);

    always_comb begin
        useRs     = (modeSel == MODE_JR) || (modeSel == MODE_JALR);
        base      = useRs ? rs : pc;
        sum       = base + imm_ext;
        // Same-sign operands whose sum changes sign; mixed signs cannot overflow.
        overflow  = (base[WIDTH-1] == imm_ext[WIDTH-1]) && (sum[WIDTH-1] != base[WIDTH-1]);
        linkAddr  = pc + WIDTH'(PC_INC);
        isReturn  = useRs && rs_is_link;
        doPush    = (modeSel == MODE_JALR) || (modeSel == MODE_JAL);
        popHit    = isReturn && (rasCount != '0);
        // Power-of-two depth: pointer arithmetic wraps naturally.
        topMinus1 = rasTop - 1'b1;
        predVal   = rasMem[topMinus1];
        accept    = valid_in && !stall && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out  <= 1'b0;
            target     <= '0;
            link       <= '0;
            link_we    <= 1'b0;
            err        <= 1'b0;
            misalign   <= 1'b0;
            ras_hit    <= 1'b0;
            ras_pred   <= '0;
            mispredict <= 1'b0;
            rasTop     <= '0;
            rasCount   <= '0;
            rasMem     <= '{default: '0};
        end else if (!stall) begin
            if (accept) begin
                valid_out  <= 1'b1;
                target     <= sum;
                link       <= linkAddr;
                link_we    <= doPush;
                err        <= overflow;
                misalign   <= sum[0];
                ras_hit    <= popHit;
                ras_pred   <= popHit ? predVal : '0;
                mispredict <= popHit && (predVal != sum);

                if (popHit && doPush) begin
                    // Pop then push collapses to replacing the top entry.
                    rasMem[topMinus1] <= linkAddr;
                end else if (popHit) begin
                    rasTop   <= topMinus1;
                    rasCount <= rasCount - 1'b1;
                end else if (doPush) begin
                    // When full, this overwrites the oldest entry.
                    rasMem[rasTop] <= linkAddr;
                    rasTop         <= rasTop + 1'b1;
                    if (rasCount != RAS_FULL) begin
                        rasCount <= rasCount + 1'b1;
                    end
                end
            end else begin
                // Idle or flushed: the stage empties; target/link keep stale data.
                valid_out  <= 1'b0;
                link_we    <= 1'b0;
                err        <= 1'b0;
                misalign   <= 1'b0;
                ras_hit    <= 1'b0;
                ras_pred   <= '0;
                mispredict <= 1'b0;
            end
        end
    end

    assign ras_count = rasCount;

endmodule

// File: doc/jump_target_unit.md
Name: jump_target_unit

Overview:
- Parametrised successor of the single-mode JR/JALR target adder.
- Computes the jump target for four modes: PC-relative, register-indirect, and each of those with link.
- Registers the result through one pipeline stage with stall and flush.
- Flags signed overflow and misaligned targets, and holds a circular return-address stack (RAS) that predicts return targets and reports mispredictions.
- Sits between decode and the fetch-redirect logic.

Parameters:
WIDTH, 16, datapath width of PC, Rs, immediate, target and link.
RAS_DEPTH, 4, number of RAS entries; power of two, minimum 2.
PC_INC, 2, value added to PC to form the link address.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
valid_in  input  1  a jump is presented this cycle
mode  input  2  00 PC+imm, 01 Rs+imm (JR), 10 Rs+imm with link (JALR), 11 PC+imm with link (JAL)
rs_is_link  input  1  Rs is the link register (R7); marks a JR/JALR as a return
pc  input  WIDTH  PC of the jump instruction
rs  input  WIDTH  Rs register value
imm_ext  input  WIDTH  sign-extended immediate
stall  input  1  hold the output stage and RAS; block the input
flush  input  1  kill the stage contents
valid_out  output  1  output stage holds a resolved jump
target  output  WIDTH  computed jump target
link  output  WIDTH  pc+PC_INC, meaningful when link_we=1
link_we  output  1  the jump writes the link register
err  output  1  signed overflow on the target add
misalign  output  1  target bit 0 is set
ras_hit  output  1  a return popped a valid RAS entry
ras_pred  output  WIDTH  popped RAS entry (0 when ras_hit=0)
mispredict  output  1  ras_hit and ras_pred != target
ras_count  output  clog2(RAS_DEPTH)+1  number of occupied RAS entries

Behaviour:
- Reset (async, active-high):
  - All outputs 0.
  - RAS top pointer 0, ras_count 0, RAS contents 0.
- Adder:
  - base = Rs for modes 01/10, PC for modes 00/11.
  - sum = base + imm_ext, modulo 2^WIDTH; carry out discarded.
  - Overflow = operands have the same sign bit and the sum sign differs from it. Opposite signs never overflow.
- Pipeline:
  - Latency is 1 cycle: at the clk edge with valid_in=1, stall=0, flush=0, all outputs are loaded from that input.
  - With valid_in=0 (no stall, no flush), valid_out becomes 0 and all flags become 0.
  - stall=1: all output registers and RAS state hold; inputs are ignored.
  - flush=1 (and stall=0): valid_out, err, misalign, link_we, ras_hit, mispredict become 0; the input is dropped and the RAS is not updated.
  - flush has priority over valid_in; stall has priority over flush.
- err = overflow & valid. misalign = target[0] & valid. link_we = mode[1] & valid.
- RAS operations, performed in the same edge that accepts the jump:
  - Push: link mode (10 or 11) and not a return. Write link at top, top = top+1 mod RAS_DEPTH, ras_count = min(ras_count+1, RAS_DEPTH).
  - Overflow on push: pushing when full overwrites the oldest entry (pointer wraps) and ras_count stays RAS_DEPTH.
  - Pop: mode 01 or 10 with rs_is_link=1.
    - If ras_count>0: ras_pred = entry[top-1], ras_hit=1, top decrements (wrap), ras_count decrements.
    - If empty: ras_hit=0, ras_pred=0, no state change.
  - Pop and push together (mode 10 with rs_is_link=1): pop first, then push.
    - Net effect: the top entry is replaced with link and ras_count is unchanged.
    - If the RAS was empty, ras_hit=0 and the push alone occurs (count 1).
  - ras_hit, ras_pred and mispredict clear to 0 on any accepted non-return jump or idle cycle.
- No mode raises both push and pop except mode 10 with rs_is_link=1.
- Reset asserted mid-operation clears the stage and the RAS immediately. The first valid_out is possible on the first edge after reset deasserts.

Test Plan:
- Reset, then mode 01, rs=0x1000, imm=0x0010 -> next cycle: valid_out=1, target=0x1010, err=0, link_we=0, ras_count=0.
- Mode 01, rs=0x7FFF, imm=0x0001 -> target=0x8000, err=1. Then rs=0x8000, imm=0xFFFF -> target=0x7FFF, err=1. Then rs=0x7FFF, imm=0x8000 -> target=0xFFFF, err=0. Then rs=0x0000, imm=0x0003 -> misalign=1.
- Mode 11, pc=0x0100, imm=0x0020 -> target=0x0120, link=0x0102, link_we=1, ras_count=1. Then mode 01, rs_is_link=1, rs=0x0102 -> ras_hit=1, ras_pred=0x0102, mispredict=0, ras_count=0. Repeat the return with rs=0x0200 -> ras_hit=0, ras_pred=0.
- Five mode-11 pushes with pc=0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) -> ras_count=4. Then four returns pop 0x52,0x42,0x32,0x22 (0x12 overwritten); a fifth return gives ras_hit=0.
- RAS holds 0x0042. Mode 10, rs_is_link=1, rs=0x0044, pc=0x0300 -> ras_hit=1, ras_pred=0x0042, mispredict=1, link=0x0302, ras_count unchanged at 1, new top=0x0302.
- Hold stall=1 for 3 cycles with a mode-11 input -> outputs and ras_count frozen. Then flush=1 with valid_in=1 -> valid_out=0, ras_count unchanged. Assert rst mid-cycle -> all outputs 0 immediately.
